// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter slice: the FSM state
//   encoding, the byte width, and width helpers used for parameterised
//   ports and counters.
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_e;

    // Width of an index into n items; at least one bit so a lone requester
    // still has a legal grant_id port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter able to hold max_val; at least one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester handshake and the transmitter launch/complete
//   signals of the UART transmit arbiter.
//   slave  : the arbiter side (consumes requests and tx_done, drives the rest)
//   master : the requester / transmitter / status side
//   Signals:
//     req_valid[NUM_REQ]      per-requester byte valid
//     req_data[8*NUM_REQ]     byte i at [8i+7:8i]
//     req_ready[NUM_REQ]      one-hot accept
//     tx_enable, tx_byte      launch pulse and byte to the transmitter
//     tx_done                 end-of-frame pulse from the transmitter
//     grant_id, busy          owner of current frame, non-idle indicator
//     timeout_err, err_clr    sticky watchdog flag and its clear
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import uart_tx_arbiter_pkg::*;

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_enable;
    logic [BYTE_W-1:0]         tx_byte;
    logic                      tx_done;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      timeout_err;
    logic                      err_clr;

    modport slave (
        input  req_valid, req_data, tx_done, err_clr,
        output req_ready, tx_enable, tx_byte, grant_id, busy, timeout_err
    );

    modport master (
        output req_valid, req_data, tx_done, err_clr,
        input  req_ready, tx_enable, tx_byte, grant_id, busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. The search starts one position
//   after last_grant and wraps; the first set request wins.
//   Ports:
//     req[NUM_REQ]        request vector
//     last_grant[IDX_W]   index granted most recently
//     grant[NUM_REQ]      one-hot winner (all zero when no request)
//     grant_idx[IDX_W]    index of the winner (0 when no request)
//     grant_valid         at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [NUM_REQ-1:0] upper;  // requests strictly after last_grant
    logic [NUM_REQ-1:0] cand;   // the half of the ring that is searched

    always_comb begin
        // NOTE: each variable gets a default before any conditional
        // assignment; a path that leaves it unassigned would infer a latch.
        upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i > int'(last_grant)) begin
                upper[i] = req[i];
            end
        end
    end

    // If nothing lies after last_grant, wrap and take the lowest overall.
    assign cand        = (|upper) ? upper : req;
    assign grant_valid = |req;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        // Descending scan: the lowest set bit is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte requesters. A round-robin
//   winner is accepted over valid/ready, launched with a one-cycle tx_enable,
//   then the block waits for tx_done and holds off GAP_CYCLES idle cycles.
//   A watchdog raises the sticky timeout_err if tx_done never arrives.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   uart_tx_arbiter_if.slave (requester handshake, transmitter
//           launch/done, grant_id, busy, timeout_err, err_clr)
//   bus must be instantiated with the same NUM_REQ as this module.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WDOG_W = cnt_width(TIMEOUT);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);

    localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // Reset points last_grant at the top index so requester 0 wins first.
    localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                tx_enable_q, tx_enable_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic                win_valid;
    logic                accept;
    logic                wdog_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (bus.req_valid),
        .last_grant  (last_grant_q),
        .grant       (win_onehot),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    // Ready is offered only in IDLE. It is also forced low while rst is
    // asserted, because the state register already reads IDLE then.
    assign bus.req_ready = (rst && state_q == ST_IDLE) ? win_onehot : '0;

    // The winner's ready bit is set exactly when its valid is, so any valid
    // in IDLE is a transfer.
    assign accept    = (state_q == ST_IDLE) && win_valid;

    // Timeout only when tx_done is absent in the final watchdog cycle.
    assign wdog_fire = (state_q == ST_WAIT_DONE) && (wdog_q == WDOG_LAST) && !bus.tx_done;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_byte_d    = tx_byte_q;
        wdog_d       = wdog_q;
        gap_d        = gap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_byte_d    = bus.req_data[int'(win_idx) * BYTE_W +: BYTE_W];
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // tx_done is not looked at here; the watchdog starts fresh.
                wdog_d  = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.tx_done || wdog_q == WDOG_LAST) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        tx_enable_d   = (state_d == ST_LAUNCH);
        busy_d        = (state_d != ST_IDLE);
        // Set has priority over clear.
        timeout_err_d = wdog_fire | (timeout_err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= LAST_RESET;
            grant_id_q    <= '0;
            tx_byte_q     <= '0;
            tx_enable_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
            gap_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            tx_byte_q     <= tx_byte_d;
            tx_enable_q   <= tx_enable_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
            gap_q         <= gap_d;
        end
    end

    assign bus.tx_enable   = tx_enable_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. dut_gap2 (GAP_CYCLES=2) carries most
//   scenarios; dut_gap0 (GAP_CYCLES=0) covers the zero-gap return to IDLE.
//   Both use NUM_REQ=4, TIMEOUT=16. Inputs change 1 ns after a rising edge and
//   outputs are checked 3 ns after it.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int TOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus0 ();
    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus1 ();

    uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .GAP_CYCLES (2),
        .TIMEOUT    (TOUT)
    ) dut_gap2 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .GAP_CYCLES (0),
        .TIMEOUT    (TOUT)
    ) dut_gap0 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 ns into an IDLE cycle with requests set up. Runs one frame on
    // dut_gap2 with tx_done in the first WAIT_DONE cycle, and returns 1 ns
    // into the following IDLE cycle (tx_done cycle + 3).
    task automatic serve_frame(input int exp_id, input logic [7:0] exp_byte);
        #2;
        check("idle_ready", 32'(bus0.req_ready), 32'(1 << exp_id));
        check("idle_busy", 32'(bus0.busy), 0);
        cyc(); #2;
        check("launch_enable", 32'(bus0.tx_enable), 1);
        check("launch_byte", 32'(bus0.tx_byte), 32'(exp_byte));
        check("launch_grant_id", 32'(bus0.grant_id), 32'(exp_id));
        check("launch_ready", 32'(bus0.req_ready), 0);
        check("launch_busy", 32'(bus0.busy), 1);
        cyc(); bus0.tx_done = 1'b1; #2;
        check("wait_enable", 32'(bus0.tx_enable), 0);
        check("wait_byte", 32'(bus0.tx_byte), 32'(exp_byte));
        cyc(); bus0.tx_done = 1'b0; #2;
        check("gap1_ready", 32'(bus0.req_ready), 0);
        check("gap1_busy", 32'(bus0.busy), 1);
        cyc(); #2;
        check("gap2_ready", 32'(bus0.req_ready), 0);
        check("gap2_busy", 32'(bus0.busy), 1);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got no end, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        bus0.req_valid = '0; bus0.req_data = '0; bus0.tx_done = 1'b0; bus0.err_clr = 1'b0;
        bus1.req_valid = '0; bus1.req_data = '0; bus1.tx_done = 1'b0; bus1.err_clr = 1'b0;

        // ---- Reset with all four requesters waiting -------------------------
        rst = 1'b0;
        bus0.req_valid = 4'b1111;
        bus0.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        cyc(); cyc(); #2;
        check("rst_tx_enable", 32'(bus0.tx_enable), 0);
        check("rst_tx_byte", 32'(bus0.tx_byte), 0);
        check("rst_grant_id", 32'(bus0.grant_id), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_timeout_err", 32'(bus0.timeout_err), 0);
        check("rst_req_ready", 32'(bus0.req_ready), 0);
        cyc(); rst = 1'b1;

        // Round robin 0,1,2,3,0
        serve_frame(0, 8'h10);
        serve_frame(1, 8'h11);
        serve_frame(2, 8'h12);
        serve_frame(3, 8'h13);
        serve_frame(0, 8'h10);

        // ---- Single byte from requester 2 -----------------------------------
        bus0.req_valid = 4'b0100;
        bus0.req_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
        serve_frame(2, 8'hA5);
        bus0.req_valid = '0;

        // ---- GAP_CYCLES=0: IDLE one cycle after tx_done ---------------------
        bus1.req_valid = 4'b0001;
        bus1.req_data  = {24'h0, 8'h5A};
        #2;
        check("g0_idle_ready", 32'(bus1.req_ready), 32'(4'b0001));
        cyc(); #2;
        check("g0_launch_enable", 32'(bus1.tx_enable), 1);
        check("g0_launch_byte", 32'(bus1.tx_byte), 32'h5A);
        cyc(); bus1.tx_done = 1'b1; #2;
        check("g0_wait_busy", 32'(bus1.busy), 1);
        cyc(); bus1.tx_done = 1'b0; #2;
        check("g0_idle_busy", 32'(bus1.busy), 0);
        check("g0_idle_ready_again", 32'(bus1.req_ready), 32'(4'b0001));
        bus1.req_valid = '0;
        cyc(); #2;
        check("g0_no_relaunch", 32'(bus1.tx_enable), 0);

        // ---- Watchdog fires; err_clr in the same cycle loses ----------------
        bus0.req_valid = 4'b0001;
        bus0.req_data  = {24'h0, 8'h3C};
        #2;
        check("wd_a_ready", 32'(bus0.req_ready), 32'(4'b0001));
        cyc(); bus0.req_valid = '0; #2;
        check("wd_a_launch", 32'(bus0.tx_enable), 1);
        for (int i = 1; i <= TOUT; i++) begin
            cyc();
            if (i == TOUT) bus0.err_clr = 1'b1;
            #2;
            check("wd_a_flag_low", 32'(bus0.timeout_err), 0);
            check("wd_a_busy", 32'(bus0.busy), 1);
        end
        check("wd_a_byte_held", 32'(bus0.tx_byte), 32'h3C);
        cyc(); bus0.err_clr = 1'b0; #2;
        check("wd_a_flag_set", 32'(bus0.timeout_err), 1);
        cyc(); #2;
        check("wd_a_flag_sticky", 32'(bus0.timeout_err), 1);
        bus0.err_clr = 1'b1;
        cyc(); bus0.err_clr = 1'b0; #2;
        check("wd_a_flag_cleared", 32'(bus0.timeout_err), 0);
        check("wd_a_idle", 32'(bus0.busy), 0);

        // ---- tx_done on the last watchdog cycle: no error -------------------
        bus0.req_valid = 4'b0001;
        bus0.req_data  = {24'h0, 8'h3D};
        #2;
        check("wd_b_ready", 32'(bus0.req_ready), 32'(4'b0001));
        cyc(); bus0.req_valid = '0; #2;
        check("wd_b_launch", 32'(bus0.tx_enable), 1);
        for (int i = 1; i <= TOUT; i++) begin
            cyc();
            if (i == TOUT) bus0.tx_done = 1'b1;
            #2;
        end
        cyc(); bus0.tx_done = 1'b0; #2;
        check("wd_b_flag_low", 32'(bus0.timeout_err), 0);
        check("wd_b_gap_busy", 32'(bus0.busy), 1);
        cyc(); cyc();

        // ---- Timeout, then reset in the middle of the next frame ------------
        bus0.req_valid = 4'b0010;
        bus0.req_data  = {16'h0, 8'h77, 8'h0};
        #2;
        check("rm_ready", 32'(bus0.req_ready), 32'(4'b0010));
        cyc();
        for (int i = 1; i <= TOUT; i++) cyc();
        cyc(); #2;
        check("rm_flag_set", 32'(bus0.timeout_err), 1);
        cyc(); cyc(); #2;
        check("rm_back_to_back", 32'(bus0.req_ready), 32'(4'b0010));
        cyc(); cyc(); cyc(); #2;
        check("rm_pre_busy", 32'(bus0.busy), 1);
        rst = 1'b0;
        bus0.req_valid = 4'b0101;
        bus0.req_data  = {8'h00, 8'h66, 8'h00, 8'h55};
        #1;
        check("rm_tx_enable", 32'(bus0.tx_enable), 0);
        check("rm_busy", 32'(bus0.busy), 0);
        check("rm_timeout_err", 32'(bus0.timeout_err), 0);
        check("rm_grant_id", 32'(bus0.grant_id), 0);
        check("rm_tx_byte", 32'(bus0.tx_byte), 0);
        check("rm_req_ready", 32'(bus0.req_ready), 0);
        cyc(); cyc(); rst = 1'b1;
        serve_frame(0, 8'h55);

        // ---- Valid pulsed during GAP is never accepted ----------------------
        bus0.req_valid = 4'b0001;
        bus0.req_data  = {24'h0, 8'h99};
        #2;
        check("vw_ready", 32'(bus0.req_ready), 32'(4'b0001));
        cyc(); bus0.req_valid = '0; #2;
        check("vw_launch_byte", 32'(bus0.tx_byte), 32'h99);
        cyc(); bus0.tx_done = 1'b1; #2;
        cyc(); bus0.tx_done = 1'b0;
        bus0.req_valid = 4'b0010;
        bus0.req_data  = {16'h0, 8'hEE, 8'h0};
        #2;
        check("vw_gap_ready", 32'(bus0.req_ready), 0);
        cyc(); bus0.req_valid = '0; #2;
        check("vw_gap2_ready", 32'(bus0.req_ready), 0);
        cyc(); #2;
        check("vw_idle_busy", 32'(bus0.busy), 0);
        check("vw_idle_ready", 32'(bus0.req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            check("vw_no_enable", 32'(bus0.tx_enable), 0);
            check("vw_no_busy", 32'(bus0.busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration. It accepts a byte from the winning requester over a valid/ready handshake and launches the transmitter with a one-cycle enable. It then waits for frame completion and enforces a minimum inter-frame gap. A watchdog flags a transmitter that never reports completion.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
GAP_CYCLES, 2, idle clk cycles inserted after each completed frame (0 allowed)
TIMEOUT, 4096, max clk cycles in WAIT_DONE before watchdog fires (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  NUM_REQ  per-requester byte valid; held until accepted
req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i]; stable while valid
req_ready  out  NUM_REQ  combinational one-hot accept; transfer when valid&ready
tx_enable  out  1  one-cycle launch pulse to transmitter
tx_byte  out  8  byte to transmit; held from LAUNCH until WAIT_DONE exits
tx_done  in  1  one-cycle pulse from transmitter at end of stop bit
grant_id  out  max(1,$clog2(NUM_REQ))  index of requester owning the current frame
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (rst=0, async): state=IDLE, tx_enable=0, tx_byte=0, grant_id=0, timeout_err=0, req_ready=0, counters=0. last_grant=NUM_REQ-1, so requester 0 has highest priority first. Reset mid-frame aborts silently; the in-flight byte is dropped.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping; the first set bit wins.
  - req_ready[winner]=1 combinationally, all other bits 0. No req_valid set -> req_ready=0 and stay in IDLE.
  - On transfer: latch tx_byte<=req_data[winner], grant_id<=winner, last_grant<=winner, next state LAUNCH.
- LAUNCH: tx_enable=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT_DONE. A tx_done seen in LAUNCH is ignored.
- WAIT_DONE:
  - Watchdog counter increments each cycle.
  - tx_done=1 -> go to GAP if GAP_CYCLES>0, else IDLE.
  - Counter reaching TIMEOUT-1 with no tx_done -> set timeout_err, exit as for tx_done.
  - tx_done and the timeout in the same cycle: done wins; timeout_err is not set.
- GAP: count GAP_CYCLES cycles, then go to IDLE. req_ready stays 0 throughout.
- Latency: a byte accepted in cycle N has tx_enable high in cycle N+1. Minimum byte-to-byte acceptance spacing is 2 + transmitter frame time + GAP_CYCLES.
- req_ready is 0 in every state except IDLE. A requester deasserting valid before acceptance is legal; that byte is simply not taken.
- err_clr=1 clears timeout_err next cycle. If a timeout sets the flag in the same cycle, set wins.
- Counter widths: $clog2(TIMEOUT+1) and $clog2(GAP_CYCLES+1), minimum 1 bit. All counters saturate-free: they are reset on state entry.
- A single active requester may be granted back-to-back; fairness applies only among simultaneous requesters.

Decomposition:
- Shared uart_pkg: state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2, GAP=2'd3), and the byte width constant 8.
- One natural sub-module: rr_arbiter (NUM_REQ parameter; inputs req vector and last_grant; outputs one-hot grant and index; purely combinational). It is reusable for the receive-side dispatcher.
- The rest (FSM, data latch, watchdog, gap counter) lives in uart_tx_arbiter.

Test Plan:
- Reset with req_valid=4'b1111 held: after reset release, first accept is requester 0. Next accepts, each after tx_done, are 1, 2, 3, 0 in order; grant_id follows.
- Single byte: req_valid[2]=1, req_data byte2=8'hA5 in cycle N -> req_ready=4'b0100 in cycle N; tx_enable=1 and tx_byte=8'hA5 in N+1; busy=1 until GAP ends.
- Gap: tx_done pulse in cycle M with GAP_CYCLES=2 -> state IDLE and req_ready possible no earlier than cycle M+3. Repeat with GAP_CYCLES=0 -> IDLE in cycle M+1.
- Watchdog: TIMEOUT=16, never pulse tx_done -> timeout_err=1 sixteen cycles after LAUNCH. err_clr=1 clears it. Also pulse tx_done on the 16th cycle -> timeout_err stays 0.
- Reset mid-frame: assert rst=0 during WAIT_DONE -> tx_enable=0, busy=0, timeout_err=0 immediately (async). After release, requester 0 has priority.
- Valid withdrawn: req_valid[1] pulses for one cycle while the block is in GAP -> never accepted; no tx_enable issued.
